// File: rtl/full_adder_reg.sv
// One-bit full adder with registered sum/carry and a valid flag.
// Outputs change only on the rising edge of clk; formal properties are compiled under FORMAL.
module full_adder_reg (
    input  logic clk,
    input  logic rstn,
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out,
    output logic valid
);

    function automatic logic fa_sum(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // p0 -> p1: operands sampled, result registered
    always_ff @(posedge clk) begin
        if (rstn) begin
            sum       <= 1'b0;
            carry_out <= 1'b0;
            valid     <= 1'b0;
        end else begin
            sum       <= fa_sum(a, b, carry_in);
            carry_out <= fa_carry(a, b, carry_in);
            valid     <= 1'b1;
        end
    end

`ifdef FORMAL
    // Guards $past so no property looks back before the first clock edge.
    logic past_vld = 1'b0;

    always_ff @(posedge clk) begin
        past_vld <= 1'b1;
    end

    always @(posedge clk) begin
        if (past_vld) begin
            if (!$past(rstn))
                assert ({carry_out, sum} ==
                        ({1'b0, $past(a)} + {1'b0, $past(b)} + {1'b0, $past(carry_in)}));
            if ($past(rstn))
                assert (!sum && !carry_out && !valid);
            if (valid)
                assert (!$past(rstn));
            cover ($past(rstn) && rstn && !$past(a) && $past(b) && $past(carry_in)
                   && !a && b && carry_in);
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_combo_cov
        always @(posedge clk) begin
            if (past_vld)
                cover (!$past(rstn) && valid &&
                       ({$past(a), $past(b), $past(carry_in)} == 3'(gi)));
        end
    end
`endif

endmodule

// File: tb/tb_full_adder_reg.sv
// Bench for full_adder_reg: arithmetic reference model checked every cycle,
// directed literal expectations, then randomized operands with sporadic resets.
module tb_full_adder_reg;

    logic clk = 1'b0;
    logic rstn, a, b, carry_in;
    logic sum, carry_out, valid;

    int errors = 0;
    int checks = 0;

    // Reference model state: what the outputs must show after the latest edge.
    logic [1:0] exp_total;
    logic       exp_valid;
    logic       model_known = 1'b0;

    full_adder_reg dut (
        .clk       (clk),
        .rstn      (rstn),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sum       (sum),
        .carry_out (carry_out),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, got, want, $time);
        end
    endtask

    always @(posedge clk) begin
        model_known <= 1'b1;
        if (rstn) begin
            exp_total <= 2'd0;
            exp_valid <= 1'b0;
        end else begin
            exp_total <= 2'(int'(a) + int'(b) + int'(carry_in));
            exp_valid <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (model_known) begin
            chk("model_total", {carry_out, sum}, exp_total);
            chk("model_valid", {1'b0, valid}, {1'b0, exp_valid});
        end
    end

    // Apply one operand set, let one edge pass, then settle just after it.
    task automatic cyc(input logic r, input logic x, input logic y, input logic z);
        rstn = r; a = x; b = y; carry_in = z;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic s, input logic c, input logic v);
        chk({name, "_sum"}, {1'b0, sum}, {1'b0, s});
        chk({name, "_cout"}, {1'b0, carry_out}, {1'b0, c});
        chk({name, "_valid"}, {1'b0, valid}, {1'b0, v});
    endtask

    initial begin
        logic [7:0] sum_tab;
        logic [7:0] cout_tab;
        logic [2:0] op;
        logic       r;
        sum_tab  = 8'b1001_0110;   // indexed by {a,b,carry_in}
        cout_tab = 8'b1110_1000;

        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        lit("reset_hold1", 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        lit("reset_hold2", 1'b0, 1'b0, 1'b0);

        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        lit("release_add", 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            cyc(1'b0, op[2], op[1], op[0]);
            lit($sformatf("sweep%0d", i), sum_tab[op], cout_tab[op], 1'b1);
        end

        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        lit("midstream_reset", 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        lit("resume", 1'b0, 1'b1, 1'b1);

        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        lit("toggle1", 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        lit("toggle2", 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        lit("toggle3", 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 15) == 0);
            op = 3'($urandom_range(0, 7));
            cyc(r, op[2], op[1], op[0]);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
